// File: rtl/alu_share_arb.sv
// Two-requester round-robin front end for one shared ALU: captures each request,
// issues at most one op per cycle and holds each result until its requester takes it.
module alu_share_arb #(
   parameter int W      = 32,
   parameter int OPW    = 5,
   parameter int MAX_OP = 16,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             r0_req_valid,
   output logic             r0_req_ready,
   input  logic [OPW-1:0]   r0_op,
   input  logic [W-1:0]     r0_a,
   input  logic [W-1:0]     r0_b,
   output logic             r0_rsp_valid,
   input  logic             r0_rsp_ready,
   output logic [W-1:0]     r0_rsp_data,
   output logic             r0_rsp_zero,
   output logic             r0_rsp_ovf,
   output logic             r0_rsp_err,
   output logic [CNT_W-1:0] r0_grant_cnt,
   input  logic             r1_req_valid,
   output logic             r1_req_ready,
   input  logic [OPW-1:0]   r1_op,
   input  logic [W-1:0]     r1_a,
   input  logic [W-1:0]     r1_b,
   output logic             r1_rsp_valid,
   input  logic             r1_rsp_ready,
   output logic [W-1:0]     r1_rsp_data,
   output logic             r1_rsp_zero,
   output logic             r1_rsp_ovf,
   output logic             r1_rsp_err,
   output logic [CNT_W-1:0] r1_grant_cnt,
   output logic [OPW-1:0]   alu_op,
   output logic [W-1:0]     alu_a,
   output logic [W-1:0]     alu_b,
   output logic             alu_busy,
   input  logic [W-1:0]     alu_out,
   input  logic             alu_zero,
   input  logic             alu_ovf
);

   typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, DONE = 2'd2} st_t;

   st_t              st_p0  [2];
   st_t              st_nxt [2];
   logic             last_gnt;
   logic [1:0]       req_vld, rsp_rdy, pend, gnt, legal;
   logic [OPW-1:0]   op_in  [2];
   logic [W-1:0]     a_in   [2];
   logic [W-1:0]     b_in   [2];
   logic [OPW-1:0]   op_p0  [2];
   logic [W-1:0]     a_p0   [2];
   logic [W-1:0]     b_p0   [2];
   logic [W-1:0]     data_p1 [2];
   logic [1:0]       zero_p1, ovf_p1, err_p1;
   logic [CNT_W-1:0] cnt_p1 [2];

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   assign req_vld = {r1_req_valid, r0_req_valid};
   assign rsp_rdy = {r1_rsp_ready, r0_rsp_ready};
   assign op_in[0] = r0_op;
   assign op_in[1] = r1_op;
   assign a_in[0]  = r0_a;
   assign a_in[1]  = r1_a;
   assign b_in[0]  = r0_b;
   assign b_in[1]  = r1_b;

   // Arbitration: a lone pending requester wins; on a tie the one not granted last wins
   always_comb begin
      pend  = '0;
      legal = '0;
      gnt   = '0;
      for (int k = 0; k < 2; k++) begin
         pend[k]  = (st_p0[k] == PEND);
         legal[k] = (op_p0[k] <= OPW'(MAX_OP));
      end
      gnt[0] = pend[0] && (!pend[1] ||  last_gnt);
      gnt[1] = pend[1] && (!pend[0] || !last_gnt);
   end

   // Illegal ops still consume the grant slot but never reach the ALU
   always_comb begin
      alu_op   = '0;
      alu_a    = '0;
      alu_b    = '0;
      alu_busy = 1'b0;
      for (int k = 0; k < 2; k++) begin
         if (gnt[k] && legal[k]) begin
            alu_op   = op_p0[k];
            alu_a    = a_p0[k];
            alu_b    = b_p0[k];
            alu_busy = 1'b1;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < 2; k++) begin
         st_nxt[k] = st_p0[k];
         case (st_p0[k])
            IDLE:    if (req_vld[k]) st_nxt[k] = PEND;
            PEND:    if (gnt[k])     st_nxt[k] = DONE;
            DONE:    if (rsp_rdy[k]) st_nxt[k] = IDLE;
            default: st_nxt[k] = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            st_p0[k]  <= IDLE;
            cnt_p1[k] <= '0;
         end
         last_gnt <= 1'b1;
      end else begin
         for (int k = 0; k < 2; k++) begin
            st_p0[k] <= st_nxt[k];
            if (gnt[k]) cnt_p1[k] <= sat_inc(cnt_p1[k]);
         end
         if (gnt[0])      last_gnt <= 1'b0;
         else if (gnt[1]) last_gnt <= 1'b1;
      end
   end

   // Stage p0 holds the captured request; stage p1 holds the response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            op_p0[k]   <= '0;
            a_p0[k]    <= '0;
            b_p0[k]    <= '0;
            data_p1[k] <= '0;
         end
         zero_p1 <= '0;
         ovf_p1  <= '0;
         err_p1  <= '0;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (st_p0[k] == IDLE && req_vld[k]) begin
               op_p0[k] <= op_in[k];
               a_p0[k]  <= a_in[k];
               b_p0[k]  <= b_in[k];
            end
            if (gnt[k]) begin
               if (legal[k]) begin
                  data_p1[k] <= alu_out;
                  zero_p1[k] <= alu_zero;
                  ovf_p1[k]  <= alu_ovf;
                  err_p1[k]  <= 1'b0;
               end else begin
                  data_p1[k] <= '0;
                  zero_p1[k] <= 1'b1;
                  ovf_p1[k]  <= 1'b0;
                  err_p1[k]  <= 1'b1;
               end
            end
         end
      end
   end

   assign r0_req_ready = (st_p0[0] == IDLE);
   assign r1_req_ready = (st_p0[1] == IDLE);
   assign r0_rsp_valid = (st_p0[0] == DONE);
   assign r1_rsp_valid = (st_p0[1] == DONE);
   assign r0_rsp_data  = data_p1[0];
   assign r1_rsp_data  = data_p1[1];
   assign r0_rsp_zero  = zero_p1[0];
   assign r1_rsp_zero  = zero_p1[1];
   assign r0_rsp_ovf   = ovf_p1[0];
   assign r1_rsp_ovf   = ovf_p1[1];
   assign r0_rsp_err   = err_p1[0];
   assign r1_rsp_err   = err_p1[1];
   assign r0_grant_cnt = cnt_p1[0];
   assign r1_grant_cnt = cnt_p1[1];

endmodule

// File: tb/tb_alu_share_arb.sv
// Bench for alu_share_arb: directed scenarios plus random traffic, all checked
// against a transaction-level model of the two requesters and the arbiter.
module tb_alu_share_arb;
   localparam int W      = 32;
   localparam int OPW    = 5;
   localparam int MAX_OP = 16;
   localparam int CW     = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]     req_valid, req_ready, rsp_valid, rsp_ready, rsp_zero, rsp_ovf, rsp_err;
   logic [OPW-1:0] op [2];
   logic [W-1:0]   a [2];
   logic [W-1:0]   b [2];
   logic [W-1:0]   rsp_data [2];
   logic [CW-1:0]  gcnt [2];
   logic [OPW-1:0] alu_op;
   logic [W-1:0]   alu_a, alu_b, alu_out;
   logic           alu_busy, alu_zero, alu_ovf;

   int n_chk = 0;
   int n_fail = 0;

   alu_share_arb #(.W(W), .OPW(OPW), .MAX_OP(MAX_OP), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_req_valid(req_valid[0]), .r0_req_ready(req_ready[0]), .r0_op(op[0]), .r0_a(a[0]), .r0_b(b[0]),
      .r0_rsp_valid(rsp_valid[0]), .r0_rsp_ready(rsp_ready[0]), .r0_rsp_data(rsp_data[0]),
      .r0_rsp_zero(rsp_zero[0]), .r0_rsp_ovf(rsp_ovf[0]), .r0_rsp_err(rsp_err[0]), .r0_grant_cnt(gcnt[0]),
      .r1_req_valid(req_valid[1]), .r1_req_ready(req_ready[1]), .r1_op(op[1]), .r1_a(a[1]), .r1_b(b[1]),
      .r1_rsp_valid(rsp_valid[1]), .r1_rsp_ready(rsp_ready[1]), .r1_rsp_data(rsp_data[1]),
      .r1_rsp_zero(rsp_zero[1]), .r1_rsp_ovf(rsp_ovf[1]), .r1_rsp_err(rsp_err[1]), .r1_grant_cnt(gcnt[1]),
      .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_busy(alu_busy),
      .alu_out(alu_out), .alu_zero(alu_zero), .alu_ovf(alu_ovf)
   );

   // Reference ALU; illegal codes yield junk so a leak into the response is visible
   function automatic void ref_alu(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                                   output logic [31:0] r, output logic z, output logic v);
      r = '0;
      v = 1'b0;
      case (o)
         5'd0:  begin r = x + y; v = (x[31] == y[31]) && (r[31] != x[31]); end
         5'd1:  r = x - y;
         5'd2:  r = x & y;
         5'd3:  r = x | y;
         5'd4:  r = x ^ y;
         5'd5:  r = x << y[4:0];
         5'd6:  r = x >> y[4:0];
         5'd7:  r = 32'($signed(x) >>> y[4:0]);
         5'd8:  r = {31'b0, $signed(x) < $signed(y)};
         5'd9:  r = {31'b0, x < y};
         5'd10: r = ~(x | y);
         5'd16: r = {y[19:0], 12'b0};
         default: begin
            if (o <= 5'd16) r = x + 32'(o);
            else begin r = 32'hDEAD_BEEF; v = 1'b1; end
         end
      endcase
      z = (r == 32'd0);
   endfunction

   always_comb ref_alu(alu_op, alu_a, alu_b, alu_out, alu_zero, alu_ovf);

   bit          m_pend [2];
   bit          m_done [2];
   logic [4:0]  m_op [2];
   logic [31:0] m_a [2];
   logic [31:0] m_b [2];
   logic [31:0] m_data [2];
   logic        m_zero [2];
   logic        m_ovf [2];
   logic        m_err [2];
   int          m_cnt [2];
   int          m_last;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_pend[k] = 0; m_done[k] = 0; m_op[k] = '0; m_a[k] = '0; m_b[k] = '0;
         m_data[k] = '0; m_zero[k] = 1'b0; m_ovf[k] = 1'b0; m_err[k] = 1'b0; m_cnt[k] = 0;
      end
      m_last = 1;
   endtask

   function automatic int arb_pick();
      if (m_pend[0] && m_pend[1]) return (m_last == 1) ? 0 : 1;
      if (m_pend[0]) return 0;
      if (m_pend[1]) return 1;
      return -1;
   endfunction

   task automatic model_step();
      int who;
      who = arb_pick();
      for (int k = 0; k < 2; k++) begin
         if (!m_pend[k] && !m_done[k]) begin
            if (req_valid[k]) begin
               m_op[k] = op[k]; m_a[k] = a[k]; m_b[k] = b[k]; m_pend[k] = 1;
            end
         end else if (m_pend[k]) begin
            if (who == k) begin
               if (m_op[k] > 5'(MAX_OP)) begin
                  m_data[k] = '0; m_zero[k] = 1'b1; m_ovf[k] = 1'b0; m_err[k] = 1'b1;
               end else begin
                  ref_alu(m_op[k], m_a[k], m_b[k], m_data[k], m_zero[k], m_ovf[k]);
                  m_err[k] = 1'b0;
               end
               m_pend[k] = 0;
               m_done[k] = 1;
               if (m_cnt[k] < (1 << CW) - 1) m_cnt[k]++;
            end
         end else if (rsp_ready[k]) begin
            m_done[k] = 0;
         end
      end
      if (who >= 0) m_last = who;
   endtask

   task automatic check_all();
      int who;
      logic busy;
      logic [4:0] eop;
      logic [31:0] ea, eb;
      who = arb_pick();
      busy = 1'b0; eop = '0; ea = '0; eb = '0;
      if (who >= 0) begin
         if (m_op[who] <= 5'(MAX_OP)) begin
            busy = 1'b1; eop = m_op[who]; ea = m_a[who]; eb = m_b[who];
         end
      end
      chk("alu_busy", 64'(alu_busy), 64'(busy));
      chk("alu_op", 64'(alu_op), 64'(eop));
      chk("alu_a", 64'(alu_a), 64'(ea));
      chk("alu_b", 64'(alu_b), 64'(eb));
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("r%0d_req_ready", k), 64'(req_ready[k]), 64'(!m_pend[k] && !m_done[k]));
         chk($sformatf("r%0d_rsp_valid", k), 64'(rsp_valid[k]), 64'(m_done[k]));
         chk($sformatf("r%0d_rsp_data", k), 64'(rsp_data[k]), 64'(m_data[k]));
         chk($sformatf("r%0d_rsp_zero", k), 64'(rsp_zero[k]), 64'(m_zero[k]));
         chk($sformatf("r%0d_rsp_ovf", k), 64'(rsp_ovf[k]), 64'(m_ovf[k]));
         chk($sformatf("r%0d_rsp_err", k), 64'(rsp_err[k]), 64'(m_err[k]));
         chk($sformatf("r%0d_grant_cnt", k), 64'(gcnt[k]), 64'(m_cnt[k]));
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = '0;
      rsp_ready = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      rst_n = 1'b1;
   endtask

   task automatic set_req(input int k, input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
      req_valid[k] = 1'b1; op[k] = o; a[k] = x; b[k] = y;
   endtask

   initial begin
      int c0;
      req_valid = '0; rsp_ready = '0;
      for (int k = 0; k < 2; k++) begin op[k] = '0; a[k] = '0; b[k] = '0; end

      // single add, response held for three cycles, then consumed
      do_reset();
      chk("reset_req_ready", 64'(req_ready), 64'(2'b11));
      set_req(0, 5'd0, 32'd5, 32'd7);
      cyc();
      req_valid = '0;
      chk("t1_alu_op", 64'(alu_op), 64'd0);
      chk("t1_alu_a", 64'(alu_a), 64'd5);
      chk("t1_alu_b", 64'(alu_b), 64'd7);
      chk("t1_alu_busy", 64'(alu_busy), 64'd1);
      cyc();
      chk("t2_rsp_valid", 64'(rsp_valid[0]), 64'd1);
      chk("t2_rsp_data", 64'(rsp_data[0]), 64'd12);
      chk("t2_rsp_flags", 64'({rsp_zero[0], rsp_ovf[0]}), 64'd0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("hold_rsp_valid", 64'(rsp_valid[0]), 64'd1);
         chk("hold_rsp_data", 64'(rsp_data[0]), 64'd12);
      end
      rsp_ready[0] = 1'b1;
      cyc();
      rsp_ready[0] = 1'b0;
      chk("consume_req_ready", 64'(req_ready[0]), 64'd1);
      chk("consume_rsp_data_kept", 64'(rsp_data[0]), 64'd12);

      // simultaneous requests: r0 wins after reset, r1 one cycle later
      do_reset();
      for (int rep = 0; rep < 2; rep++) begin
         set_req(0, 5'd1, 32'd9, 32'd9);
         set_req(1, 5'd3, 32'hF0, 32'h0F);
         cyc();
         req_valid = '0;
         chk("pair_first_op", 64'(alu_op), 64'd1);
         cyc();
         chk("pair_r0_valid", 64'(rsp_valid), 64'(2'b01));
         chk("pair_r0_data", 64'(rsp_data[0]), 64'd0);
         chk("pair_r0_zero", 64'(rsp_zero[0]), 64'd1);
         cyc();
         chk("pair_r1_valid", 64'(rsp_valid[1]), 64'd1);
         chk("pair_r1_data", 64'(rsp_data[1]), 64'hFF);
         rsp_ready = 2'b11;
         cyc();
         rsp_ready = 2'b00;
      end

      // r0 granted last, so the next tie goes to r1
      set_req(0, 5'd2, 32'h3C, 32'h0F);
      cyc();
      req_valid = '0;
      cyc();
      rsp_ready[0] = 1'b1;
      cyc();
      rsp_ready[0] = 1'b0;
      set_req(0, 5'd4, 32'hAA, 32'h55);
      set_req(1, 5'd16, 32'd0, 32'h12345);
      cyc();
      req_valid = '0;
      chk("alt_first_op", 64'(alu_op), 64'd16);
      cyc();
      chk("alt_r1_first", 64'(rsp_valid), 64'(2'b10));
      chk("alt_r1_data", 64'(rsp_data[1]), 64'h12345000);
      cyc();
      chk("alt_r0_data", 64'(rsp_data[0]), 64'hFF);
      rsp_ready = 2'b11;
      cyc();
      rsp_ready = 2'b00;

      // signed overflow on add
      set_req(1, 5'd0, 32'h7FFF_FFFF, 32'd1);
      cyc();
      req_valid = '0;
      cyc();
      chk("ovf_data", 64'(rsp_data[1]), 64'h8000_0000);
      chk("ovf_flag", 64'(rsp_ovf[1]), 64'd1);
      rsp_ready[1] = 1'b1;
      cyc();
      rsp_ready[1] = 1'b0;

      // illegal op code
      c0 = int'(gcnt[0]);
      set_req(0, 5'b10011, 32'd3, 32'd4);
      cyc();
      req_valid = '0;
      chk("illegal_busy", 64'(alu_busy), 64'd0);
      chk("illegal_alu_op", 64'(alu_op), 64'd0);
      cyc();
      chk("illegal_err", 64'(rsp_err[0]), 64'd1);
      chk("illegal_data", 64'(rsp_data[0]), 64'd0);
      chk("illegal_zero", 64'(rsp_zero[0]), 64'd1);
      chk("illegal_cnt", 64'(gcnt[0]), 64'(c0 + 1));
      rsp_ready[0] = 1'b1;
      cyc();
      rsp_ready[0] = 1'b0;

      // back-to-back r0 traffic until the grant counter saturates
      do_reset();
      req_valid[0] = 1'b1;
      rsp_ready[0] = 1'b1;
      for (int i = 0; i < 3 * ((1 << CW) + 3) + 3; i++) begin
         op[0] = 5'($urandom_range(0, MAX_OP));
         a[0] = $urandom;
         b[0] = $urandom;
         cyc();
      end
      req_valid = '0;
      rsp_ready = '0;
      chk("sat_r0_cnt", 64'(gcnt[0]), 64'((1 << CW) - 1));
      chk("sat_r1_cnt", 64'(gcnt[1]), 64'd0);

      // reset with r0 pending and r1 holding a response
      do_reset();
      set_req(1, 5'd3, 32'h1, 32'h2);
      cyc();
      req_valid = '0;
      cyc();
      set_req(0, 5'd0, 32'd10, 32'd20);
      cyc();
      req_valid = '0;
      chk("pre_rst_busy", 64'(alu_busy), 64'd1);
      chk("pre_rst_r1_valid", 64'(rsp_valid[1]), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_req_ready", 64'(req_ready), 64'(2'b11));
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_alu_busy", 64'(alu_busy), 64'd0);
      chk("rst_cnt0", 64'(gcnt[0]), 64'd0);
      chk("rst_cnt1", 64'(gcnt[1]), 64'd0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("post_rst_no_rsp", 64'(rsp_valid), 64'd0);
      end

      // random traffic
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         for (int k = 0; k < 2; k++) begin
            req_valid[k] = ($urandom_range(0, 3) != 0);
            rsp_ready[k] = ($urandom_range(0, 1) != 0);
            op[k] = 5'($urandom_range(0, 20));
            a[k] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            b[k] = ($urandom_range(0, 3) == 0) ? a[k] : $urandom;
         end
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
